// File: rtl/ahb_load_unit.sv
// AHB-Lite master read engine for the core's load path.
// Runs one single-beat read per request, then extracts and extends the addressed
// byte, halfword or word. Misaligned or illegal requests skip the bus entirely.
module ahb_load_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [2:0]        ld_funct3,
  output logic              ld_busy,
  output logic              ld_valid,
  output logic [DATA_W-1:0] ld_data,
  output logic              ld_err,
  output logic [ADDR_W-1:0] haddr,
  output logic [1:0]        htrans,
  output logic              hwrite,
  output logic [2:0]        hsize,
  input  logic [DATA_W-1:0] hrdata,
  input  logic              hready,
  input  logic              hresp
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    RESP,
    ERR
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        funct3_q;
  logic              req_bad;
  logic [DATA_W-1:0] byte_shift;
  logic [DATA_W-1:0] half_shift;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;
  logic [DATA_W-1:0] ext_data;

  // Address-phase signals come straight from the latched request.
  assign haddr  = addr_q;
  assign hsize  = {1'b0, funct3_q[1:0]};
  assign hwrite = 1'b0;

  // Classify the incoming request: illegal funct3 or misaligned halfword/word.
  always_comb begin
    req_bad = 1'b0;
    if (ld_funct3 == 3'b011 || ld_funct3[2:1] == 2'b11)
      req_bad = 1'b1;
    else if (ld_funct3[1:0] == 2'b01 && ld_addr[0])
      req_bad = 1'b1;
    else if (ld_funct3 == 3'b010 && ld_addr[1:0] != 2'b00)
      req_bad = 1'b1;
  end

  // Pick the addressed lane out of the read data and sign/zero-extend it.
  always_comb begin
    byte_shift = hrdata >> {addr_q[1:0], 3'b000};
    half_shift = hrdata >> {addr_q[1], 4'b0000};
    byte_v     = byte_shift[7:0];
    half_v     = half_shift[15:0];
    case (funct3_q)
      3'b000:  ext_data = {{24{byte_v[7]}}, byte_v};
      3'b001:  ext_data = {{16{half_v[15]}}, half_v};
      3'b100:  ext_data = {24'd0, byte_v};
      3'b101:  ext_data = {16'd0, half_v};
      default: ext_data = hrdata;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= next_state;
  end

  // Next-state logic and per-state bus/handshake outputs.
  always_comb begin
    next_state = state;
    htrans     = 2'b00;
    ld_busy    = 1'b0;
    ld_valid   = 1'b0;
    case (state)
      IDLE: begin
        if (ld_req)
          next_state = req_bad ? ERR : ADDR;
      end
      ADDR: begin
        htrans  = 2'b10;
        ld_busy = 1'b1;
        if (hready)
          next_state = DATA;
      end
      DATA: begin
        ld_busy = 1'b1;
        if (hready)
          next_state = RESP;
      end
      ERR: begin
        ld_busy    = 1'b1;
        next_state = RESP;
      end
      RESP: begin
        ld_valid   = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Request latch and result capture; results hold until the next completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= '0;
      funct3_q <= 3'b000;
      ld_data  <= '0;
      ld_err   <= 1'b0;
    end else begin
      if (state == IDLE && ld_req) begin
        addr_q   <= ld_addr;
        funct3_q <= ld_funct3;
      end
      if (state == DATA && hready) begin
        ld_err  <= hresp;
        ld_data <= hresp ? '0 : ext_data;
      end
      if (state == ERR) begin
        ld_err  <= 1'b1;
        ld_data <= '0;
      end
    end
  end

endmodule
